// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Widths, fetch defaults, fetch FSM state encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_0000;
  localparam int                DEF_PC_STEP  = 4;

  localparam logic [1:0] FS_IDLE = 2'b00;
  localparam logic [1:0] FS_WAIT = 2'b01;
  localparam logic [1:0] FS_HOLD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = FS_IDLE,
    ST_WAIT = FS_WAIT,
    ST_HOLD = FS_HOLD
  } fetch_state_e;

  function automatic logic [ADDR_W-1:0] align_pc(
    input logic [ADDR_W-1:0] a
  );
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack memory side, valid/taken IR side.
// Ports: Clk, Reset_n | MemReq/MemAddr/MemRdata/MemAck |
//   IROut/PCOut/IRValid/IRTaken | Redirect/RedirectPC | FetchErr.
// Optional WAIT timeout with FetchErr pulse: FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC       = DEF_RESET_PC,
  parameter int                PC_STEP        = DEF_PC_STEP,
  parameter int                TIMEOUT_CYCLES = 16
) (
  input  logic               Clk,
  input  logic               Reset_n,
  output logic               MemReq,
  output logic [ADDR_W-1:0]  MemAddr,
  input  logic [INSTR_W-1:0] MemRdata,
  input  logic               MemAck,
  output logic [INSTR_W-1:0] IROut,
  output logic [ADDR_W-1:0]  PCOut,
  output logic               IRValid,
  input  logic               IRTaken,
  input  logic               Redirect,
  input  logic [ADDR_W-1:0]  RedirectPC,
  output logic               FetchErr
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_e state_q, state_d;

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic               disc_q, disc_d;
  logic               req_q, req_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0]  pco_q, pco_d;
  logic               vld_q, vld_d;
  logic               ferr_q, ferr_d;

  logic              in_idle, in_wait, in_hold;
  logic              launch, keep, drop, park, tmo;
  logic [ADDR_W-1:0] tgt;

  assign in_idle = (state_q == ST_IDLE);
  assign in_wait = (state_q == ST_WAIT);
  assign in_hold = (state_q == ST_HOLD);
  assign tgt     = align_pc(RedirectPC);

  // Redirect wins in IDLE/HOLD; IRTaken alone advances.
  assign launch = in_idle
                | (in_hold & (Redirect | IRTaken));
  assign keep   = in_wait & MemAck
                & ~disc_q & ~Redirect;
  // Stale or redirected response is thrown away.
  assign drop   = in_wait & MemAck
                & (disc_q | Redirect);
  // Request cannot be withdrawn: remember to drop it.
  assign park   = in_wait & ~MemAck
                & Redirect & ~tmo;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q;

  assign tmo = in_wait & ~MemAck
             & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= '0;
    end else if (in_wait && !MemAck) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (MemAck) begin
          state_d = (disc_q || Redirect)
                  ? ST_IDLE : ST_HOLD;
        end else if (tmo) begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (Redirect || IRTaken) begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    disc_d = disc_q;
    req_d  = req_q;
    addr_d = addr_q;
    ir_d   = ir_q;
    pco_d  = pco_q;
    vld_d  = vld_q;
    ferr_d = tmo;
    unique case (1'b1)
      launch: begin
        req_d  = 1'b1;
        vld_d  = 1'b0;
        pc_d   = Redirect ? tgt : pc_q;
        addr_d = Redirect ? tgt : pc_q;
      end
      keep: begin
        ir_d  = MemRdata;
        pco_d = addr_q;
        vld_d = 1'b1;
        pc_d  = addr_q + ADDR_W'(PC_STEP);
        req_d = 1'b0;
      end
      drop, tmo: begin
        req_d  = 1'b0;
        disc_d = 1'b0;
        if (Redirect) pc_d = tgt;
      end
      park: begin
        disc_d = 1'b1;
        pc_d   = tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q   <= RESET_PC;
      disc_q <= 1'b0;
      req_q  <= 1'b0;
      addr_q <= RESET_PC;
      ir_q   <= '0;
      pco_q  <= '0;
      vld_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      disc_q <= disc_d;
      req_q  <= req_d;
      addr_q <= addr_d;
      ir_q   <= ir_d;
      pco_q  <= pco_d;
      vld_q  <= vld_d;
      ferr_q <= ferr_d;
    end
  end

  assign MemReq   = req_q;
  assign MemAddr  = addr_q;
  assign IROut    = ir_q;
  assign PCOut    = pco_q;
  assign IRValid  = vld_q;
  assign FetchErr = ferr_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed and random fetch,
// stall, redirect, wrap, timeout and async reset scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ir_out;
  logic [31:0] pc_out;
  logic        ir_valid;
  logic        ir_taken;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .PC_STEP(4),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .Clk(clk),
    .Reset_n(rst_n),
    .MemReq(mem_req),
    .MemAddr(mem_addr),
    .MemRdata(mem_rdata),
    .MemAck(mem_ack),
    .IROut(ir_out),
    .PCOut(pc_out),
    .IRValid(ir_valid),
    .IRTaken(ir_taken),
    .Redirect(redirect),
    .RedirectPC(redirect_pc),
    .FetchErr(fetch_err)
  );

  int ncmp = 0;
  int nerr = 0;

  int lat = 0;
  bit mem_on = 1'b1;
  int ack_cnt = 0;

  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_vld = 1'b0;
  bit          req_seen = 1'b0;
  logic [31:0] req_addr = '0;
  bit          vld_seen = 1'b0;

  logic [31:0] salt;
  logic [31:0] exp_pc;
  logic [31:0] rp;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, then play memory.
  task automatic tick();
    @(posedge clk);
    #1;
    if (mem_req && prev_req)
      chk("addr_stable", mem_addr, prev_addr);
    if (mem_req && !prev_req) begin
      req_seen = 1'b1;
      req_addr = mem_addr;
    end
    if (ir_valid && !prev_vld) vld_seen = 1'b1;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    prev_vld  = ir_valid;
    mem_ack = 1'b0;
    if (mem_req && mem_on) begin
      if (ack_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = word(mem_addr);
        ack_cnt   = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  endtask

  task automatic wait_req(input string tag,
                          input logic [31:0] exp);
    for (int n = 0; n < 60 && !req_seen; n++) tick();
    chk({tag, "_seen"}, 32'(req_seen), 32'd1);
    if (req_seen) chk(tag, req_addr, exp);
    req_seen = 1'b0;
  endtask

  task automatic wait_valid(input string tag,
                            input logic [31:0] exp);
    for (int n = 0; n < 60 && !vld_seen; n++) tick();
    chk({tag, "_seen"}, 32'(vld_seen), 32'd1);
    if (vld_seen) begin
      chk({tag, "_pc"}, pc_out, exp);
      chk({tag, "_ir"}, ir_out, word(exp));
    end
    vld_seen = 1'b0;
  endtask

  initial begin
    salt        = $urandom;
    ir_taken    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_ir", ir_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_vld", 32'(ir_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    rst_n = 1'b1;

    // first fetch, then stall on it
    lat = 0;
    wait_req("req0", 32'h0);
    wait_valid("ir0", 32'h0);
    repeat (10) begin
      tick();
      chk("stall_ir", ir_out, word(32'h0));
      chk("stall_pc", pc_out, 32'h0);
      chk("stall_vld", 32'(ir_valid), 32'd1);
      chk("stall_req", 32'(mem_req), 32'd0);
    end
    ir_taken = 1'b1;
    wait_req("req4", 32'h4);
    wait_valid("ir4", 32'h4);
    wait_req("req8", 32'h8);
    wait_valid("ir8", 32'h8);

    // redirect while waiting, late ack is dropped
    lat = 3;
    wait_req("reqC", 32'hC);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    for (int n = 0; n < 40 && !req_seen; n++) begin
      tick();
      chk("drop_vld", 32'(ir_valid), 32'd0);
    end
    wait_req("req_redir", 32'h1000);
    wait_valid("ir_redir", 32'h1000);

    // redirect in the same cycle as the ack
    lat = 0;
    wait_req("req1004", 32'h1004);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_2000;
    tick();
    redirect = 1'b0;
    chk("rda_vld", 32'(ir_valid), 32'd0);
    chk("rda_req", 32'(mem_req), 32'd0);
    wait_req("req_rda", 32'h2000);
    wait_valid("ir_rda", 32'h2000);

    // redirect in HOLD beats IRTaken; then wrap
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    ir_taken    = 1'b1;
    tick();
    redirect = 1'b0;
    wait_req("req_hold_rd", 32'hFFFF_FFFC);
    wait_valid("ir_top", 32'hFFFF_FFFC);
    wait_req("req_wrap", 32'h0);
    wait_valid("ir_wrap", 32'h0);

    // random traffic against a sequential-PC model
    exp_pc = 32'h0;
    repeat (25) begin
      int stall;
      stall = $urandom_range(0, 3);
      lat   = $urandom_range(0, 3);
      if (stall > 0) begin
        ir_taken = 1'b0;
        repeat (stall) begin
          tick();
          chk("rnd_hold_vld", 32'(ir_valid), 32'd1);
          chk("rnd_hold_pc", pc_out, exp_pc);
        end
        ir_taken = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) begin
        rp          = $urandom;
        redirect    = 1'b1;
        redirect_pc = rp;
        exp_pc      = {rp[31:2], 2'b00};
        tick();
        redirect = 1'b0;
      end else begin
        exp_pc = exp_pc + 32'd4;
      end
      wait_req("rnd_req", exp_pc);
      if ($urandom_range(0, 3) == 0) begin
        rp          = $urandom;
        redirect    = 1'b1;
        redirect_pc = rp;
        exp_pc      = {rp[31:2], 2'b00};
        tick();
        redirect = 1'b0;
        wait_req("rnd_wredir", exp_pc);
      end
      wait_valid("rnd_ir", exp_pc);
    end

    // memory never answers
    ir_taken = 1'b1;
    mem_on   = 1'b0;
    exp_pc   = exp_pc + 32'd4;
    wait_req("to_req", exp_pc);
`ifdef FETCH_TIMEOUT_EN
    repeat (3) begin
      tick();
      chk("to_err_lo", 32'(fetch_err), 32'd0);
      chk("to_req_hi", 32'(mem_req), 32'd1);
    end
    tick();
    chk("to_err_hi", 32'(fetch_err), 32'd1);
    chk("to_req_lo", 32'(mem_req), 32'd0);
    tick();
    chk("to_err_end", 32'(fetch_err), 32'd0);
    chk("to_rereq", 32'(mem_req), 32'd1);
    chk("to_readdr", mem_addr, exp_pc);
    req_seen = 1'b0;
`else
    repeat (8) begin
      tick();
      chk("nto_err", 32'(fetch_err), 32'd0);
      chk("nto_req", 32'(mem_req), 32'd1);
    end
`endif
    mem_on = 1'b1;
    wait_valid("to_ir", exp_pc);
    req_seen = 1'b0;

    // reset in the middle of a transaction
    exp_pc = exp_pc + 32'd4;
    wait_req("mr_req", exp_pc);
    rst_n = 1'b0;
    #1;
    chk("mr_req0", 32'(mem_req), 32'd0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_vld", 32'(ir_valid), 32'd0);
    chk("mr_ir", ir_out, 32'h0);
    chk("mr_pc", pc_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
